// File: rtl/sdram_if_pkg.sv
// Shared types for the SDRAM Avalon master: FSM states, queued command format,
// error flag bit positions and the word-to-byte address helper.
package sdram_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA
  } state_t;

  typedef struct packed {
    logic        is_write;
    logic [25:0] addr;
    logic [31:0] data;
  } cmd_t;

  localparam int ERR_OVF   = 0;
  localparam int ERR_PROTO = 1;

  // Byte address wraps modulo 2^32 so a high base can roll over zero.
  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] base,
                                                    input logic [25:0] word_addr);
    return base + {4'b0000, word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/sdram_cmd_fifo.sv
// In-order command queue between customLogicTLD requests and the Avalon issue FSM.
// Pointers carry an extra MSB so full and empty are distinguishable without a counter.
module sdram_cmd_fifo
  import sdram_if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sdram_avalon_master.sv
// Avalon-MM master that turns customLogicTLD read/write pulses into one-at-a-time
// SDRAM transactions, returning read data with a single-cycle valid pulse.
module sdram_avalon_master
  import sdram_if_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CMD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_read_en,
  input  logic        sdram_write_en,
  input  logic [25:0] address_sdram,
  input  logic [31:0] writeData_sdram,
  output logic [31:0] data_sdram,
  output logic        sdram_datareadvalid,
  output logic        busy,
  output logic [1:0]  err_flags,
  input  logic        err_clr,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  state_t     state, state_next;
  cmd_t       fifo_din, fifo_dout;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic       cmd_is_write;
  logic       issue_cmd, cmd_done, capture;
  logic       both_en, ovf_err, stray_err;
  logic [1:0] err_next;

  // Simultaneous enables keep the read; the write is dropped and flagged.
  assign both_en   = sdram_read_en && sdram_write_en;
  assign fifo_push = sdram_read_en || sdram_write_en;
  assign fifo_din  = {sdram_write_en & ~sdram_read_en, address_sdram, writeData_sdram};

  sdram_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    issue_cmd  = 1'b0;
    cmd_done   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          issue_cmd  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          cmd_done   = 1'b1;
          state_next = cmd_is_write ? IDLE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (avm_readdatavalid) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ovf_err   = fifo_push && fifo_full && !fifo_pop;
  assign stray_err = avm_readdatavalid && (state != WAIT_DATA);

  // A new error in the same cycle as err_clr must survive the clear.
  always_comb begin
    err_next            = err_clr ? 2'b00 : err_flags;
    err_next[ERR_OVF]   = err_next[ERR_OVF] | ovf_err;
    err_next[ERR_PROTO] = err_next[ERR_PROTO] | both_en | stray_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Command registers load on pop and stay frozen through waitrequest stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_is_write   <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= 4'h0;
    end else if (issue_cmd) begin
      cmd_is_write   <= fifo_dout.is_write;
      avm_read       <= !fifo_dout.is_write;
      avm_write      <= fifo_dout.is_write;
      avm_address    <= word_to_byte_addr(BASE_ADDR, fifo_dout.addr);
      avm_writedata  <= fifo_dout.data;
      avm_byteenable <= 4'hF;
    end else if (cmd_done) begin
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= 4'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sdram          <= '0;
      sdram_datareadvalid <= 1'b0;
      busy                <= 1'b0;
      err_flags           <= 2'b00;
    end else begin
      sdram_datareadvalid <= capture;
      if (capture) data_sdram <= avm_readdata;
      busy                <= (state != IDLE) || !fifo_empty;
      err_flags           <= err_next;
    end
  end

endmodule
